// File: rtl/seq12_pkg.sv
// Shared definitions for the mod-12 custom-code sequence checker:
// lock states, the code table and the expected-successor function.
package seq12_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned NUM_IDX = 12;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Counter state words {Q3,Q2,Q1,Q0} for indices 0..11
  localparam logic [CODE_W-1:0] CODE_0  = 4'b1000;
  localparam logic [CODE_W-1:0] CODE_1  = 4'b1010;
  localparam logic [CODE_W-1:0] CODE_2  = 4'b1011;
  localparam logic [CODE_W-1:0] CODE_3  = 4'b1101;
  localparam logic [CODE_W-1:0] CODE_4  = 4'b1110;
  localparam logic [CODE_W-1:0] CODE_5  = 4'b1111;
  localparam logic [CODE_W-1:0] CODE_6  = 4'b0000;
  localparam logic [CODE_W-1:0] CODE_7  = 4'b0001;
  localparam logic [CODE_W-1:0] CODE_8  = 4'b0010;
  localparam logic [CODE_W-1:0] CODE_9  = 4'b0100;
  localparam logic [CODE_W-1:0] CODE_10 = 4'b0101;
  localparam logic [CODE_W-1:0] CODE_11 = 4'b0111;

  // The four words never produced by a healthy counter: 0011, 0110, 1001, 1100.

  function automatic logic [CODE_W-1:0] next_idx(input logic [CODE_W-1:0] cur);
    return (cur == 4'(NUM_IDX - 1)) ? '0 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/seq12_decode.sv
// Combinational lookup of a counter state word into its index 0..11.
module seq12_decode
  import seq12_pkg::*;
(
  input  logic [CODE_W-1:0] code_in,
  output logic              legal,
  output logic [CODE_W-1:0] dec
);

  always_comb begin
    legal = 1'b1;
    dec   = '0;
    case (code_in)
      CODE_0:  dec = 4'd0;
      CODE_1:  dec = 4'd1;
      CODE_2:  dec = 4'd2;
      CODE_3:  dec = 4'd3;
      CODE_4:  dec = 4'd4;
      CODE_5:  dec = 4'd5;
      CODE_6:  dec = 4'd6;
      CODE_7:  dec = 4'd7;
      CODE_8:  dec = 4'd8;
      CODE_9:  dec = 4'd9;
      CODE_10: dec = 4'd10;
      CODE_11: dec = 4'd11;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq12_code_checker.sv
// Receive-side checker for the mod-12 custom-code counter: decodes samples,
// flags illegal/out-of-order steps, tracks lock and counts sequence errors.
module seq12_code_checker
  import seq12_pkg::*;
#(
  parameter int unsigned LOCK_N   = 3,
  parameter int unsigned UNLOCK_N = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_vld,
  input  logic              err_clr,
  output logic [CODE_W-1:0] idx,
  output logic              idx_vld,
  output logic              locked,
  output logic              illegal,
  output logic              seq_err,
  output logic              wrap,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [3:0]       LOCK_V   = 4'(LOCK_N);
  localparam logic [3:0]       UNLOCK_V = 4'(UNLOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_t            state;
  logic [CODE_W-1:0] prev_idx;
  logic              have_prev;
  logic [3:0]        run_cnt;
  logic [3:0]        miss_cnt;

  logic              legal_c;
  logic [CODE_W-1:0] dec_c;
  logic              good_c;
  logic              seq_err_ev_c;
  logic [3:0]        run_nxt_c;
  logic [3:0]        miss_nxt_c;

  seq12_decode u_decode (
    .code_in (code_in),
    .legal   (legal_c),
    .dec     (dec_c)
  );

  // A step is good only when it follows a known legal predecessor in order
  assign good_c       = code_vld & legal_c & have_prev & (dec_c == next_idx(prev_idx));
  assign seq_err_ev_c = code_vld & (state == LOCKED) & ~good_c;
  assign run_nxt_c    = run_cnt + 4'd1;
  assign miss_nxt_c   = miss_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      prev_idx  <= '0;
      have_prev <= 1'b0;
      run_cnt   <= '0;
      miss_cnt  <= '0;
      idx       <= '0;
      idx_vld   <= 1'b0;
      locked    <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      idx_vld <= 1'b0;
      illegal <= 1'b0;
      seq_err <= 1'b0;
      wrap    <= 1'b0;

      if (code_vld) begin
        if (legal_c) begin
          idx       <= dec_c;
          idx_vld   <= 1'b1;
          prev_idx  <= dec_c;
          have_prev <= 1'b1;
        end else begin
          illegal   <= 1'b1;
          have_prev <= 1'b0;
        end

        case (state)
          HUNT: begin
            if (good_c) begin
              if (run_nxt_c == LOCK_V) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                run_cnt  <= '0;
                miss_cnt <= '0;
              end else begin
                run_cnt <= run_nxt_c;
              end
            end else begin
              run_cnt <= '0;
            end
          end
          LOCKED: begin
            if (good_c) begin
              miss_cnt <= '0;
              wrap     <= (dec_c == '0);
            end else begin
              seq_err <= 1'b1;
              if (miss_nxt_c == UNLOCK_V) begin
                state    <= HUNT;
                locked   <= 1'b0;
                run_cnt  <= '0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_nxt_c;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end

      // A clear coinciding with an error keeps that error
      if (seq_err_ev_c) begin
        if (err_clr)                err_cnt <= ERR_W'(1);
        else if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
      end else if (err_clr) begin
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seq12_code_checker.sv
// Self-checking bench for seq12_code_checker: directed scenarios plus a
// randomized run against an index-arithmetic reference model.
module tb_seq12_code_checker;

  localparam int unsigned LOCK_N   = 3;
  localparam int unsigned UNLOCK_N = 2;
  localparam int unsigned ERR_W    = 8;
  localparam int          ERR_SAT  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       code_in;
  logic             code_vld;
  logic             err_clr;
  logic [3:0]       idx;
  logic             idx_vld;
  logic             locked;
  logic             illegal;
  logic             seq_err;
  logic             wrap;
  logic [ERR_W-1:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] tbl [12] = '{4'b1000, 4'b1010, 4'b1011, 4'b1101, 4'b1110, 4'b1111,
                           4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0111};

  // Reference model state (indices as plain integers)
  int   m_prev, m_have, m_run, m_miss, m_locked, m_err;
  logic [3:0] e_idx;
  logic e_idx_vld, e_illegal, e_seq_err, e_wrap;

  seq12_code_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .ERR_W(ERR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .code_in  (code_in),
    .code_vld (code_vld),
    .err_clr  (err_clr),
    .idx      (idx),
    .idx_vld  (idx_vld),
    .locked   (locked),
    .illegal  (illegal),
    .seq_err  (seq_err),
    .wrap     (wrap),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int lookup(input logic [3:0] c);
    for (int i = 0; i < 12; i++) if (tbl[i] == c) return i;
    return -1;
  endfunction

  function automatic void model_step(input logic [3:0] c, input logic v, input logic clr,
                                     input logic r);
    int d;
    bit good;
    e_idx_vld = 1'b0; e_illegal = 1'b0; e_seq_err = 1'b0; e_wrap = 1'b0;
    if (r) begin
      m_prev = 0; m_have = 0; m_run = 0; m_miss = 0; m_locked = 0; m_err = 0;
      e_idx = '0;
      return;
    end
    if (v) begin
      d = lookup(c);
      good = (d >= 0) && (m_have != 0) && (d == (m_prev + 1) % 12);
      if (d >= 0) begin
        e_idx = 4'(d); e_idx_vld = 1'b1; m_prev = d; m_have = 1;
      end else begin
        e_illegal = 1'b1; m_have = 0;
      end
      if (m_locked == 0) begin
        if (good) begin
          m_run++;
          if (m_run == int'(LOCK_N)) begin m_locked = 1; m_run = 0; m_miss = 0; end
        end else m_run = 0;
      end else begin
        if (good) begin
          m_miss = 0;
          if (d == 0) e_wrap = 1'b1;
        end else begin
          e_seq_err = 1'b1;
          m_miss++;
          if (m_miss == int'(UNLOCK_N)) begin m_locked = 0; m_run = 0; m_miss = 0; end
        end
      end
    end
    if (e_seq_err) m_err = clr ? 1 : ((m_err < ERR_SAT) ? m_err + 1 : ERR_SAT);
    else if (clr) m_err = 0;
  endfunction

  // Apply one cycle of inputs, advance the model, sample #1 after the edge
  task automatic drive(input logic [3:0] c, input logic v, input logic clr, input logic r);
    code_in = c; code_vld = v; err_clr = clr; rst = r;
    model_step(c, v, clr, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(4'b0001, 1'b1, 1'b0, 1'b1);
    drive(4'b1000, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({idx, idx_vld, locked, illegal, seq_err, wrap, err_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got idx=%0d vld=%b lk=%b ill=%b se=%b wr=%b err=%0d required all 0",
               idx, idx_vld, locked, illegal, seq_err, wrap, err_cnt);
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({idx, idx_vld, seq_err} !== {4'(i), 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL lock_idx[%0d]: got idx=%0d vld=%b se=%b required idx=%0d vld=1 se=0",
                 i, idx, idx_vld, seq_err, i);
      end
      n_cmp++;
      if (locked !== (i == 3)) begin
        n_bad++;
        $display("FAIL lock_rise[%0d]: got locked=%b required %b", i, locked, i == 3);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 4; i <= 12; i++) begin
      drive(tbl[i % 12], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({wrap, idx, locked} !== {i == 12, 4'(i % 12), 1'b1}) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got wrap=%b idx=%0d lk=%b required wrap=%b idx=%0d lk=1",
                 i, wrap, idx, locked, i == 12, i % 12);
      end
    end
    n_cmp++;
    if (err_cnt !== '0) begin
      n_bad++;
      $display("FAIL wrap_err_cnt: got %0d required 0", err_cnt);
    end
  endtask

  task automatic test_illegal_unlock();
    for (int i = 1; i <= 3; i++) drive(tbl[i], 1'b1, 1'b0, 1'b0);
    drive(4'b1001, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({illegal, seq_err, idx, idx_vld, locked} !== {1'b1, 1'b1, 4'd3, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL illegal_sample: got ill=%b se=%b idx=%0d vld=%b lk=%b required 1 1 3 0 1",
               illegal, seq_err, idx, idx_vld, locked);
    end
    drive(4'b1110, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({illegal, seq_err, idx, locked} !== {1'b0, 1'b1, 4'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL unlock_after_illegal: got ill=%b se=%b idx=%0d lk=%b required 0 1 4 0",
               illegal, seq_err, idx, locked);
    end
    n_cmp++;
    if (err_cnt !== ERR_W'(2)) begin
      n_bad++;
      $display("FAIL unlock_err_cnt: got %0d required 2", err_cnt);
    end
  endtask

  task automatic test_resync();
    for (int i = 5; i <= 7; i++) drive(tbl[i], 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL relock_from_hunt: got locked=%b required 1", locked);
    end
    for (int i = 8; i <= 17; i++) drive(tbl[i % 12], 1'b1, 1'b0, 1'b0);
    drive(4'b0010, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({seq_err, idx, locked} !== {1'b1, 4'd8, 1'b1}) begin
      n_bad++;
      $display("FAIL resync_skip: got se=%b idx=%0d lk=%b required 1 8 1", seq_err, idx, locked);
    end
    drive(4'b0100, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({seq_err, idx, locked, err_cnt} !== {1'b0, 4'd9, 1'b1, ERR_W'(3)}) begin
      n_bad++;
      $display("FAIL resync_follow: got se=%b idx=%0d lk=%b err=%0d required 0 9 1 3",
               seq_err, idx, locked, err_cnt);
    end
  endtask

  task automatic test_err_saturation();
    int iter = 0;
    while (m_err < ERR_SAT && iter < 300) begin
      drive(tbl[(m_prev + 2) % 12], 1'b1, 1'b0, 1'b0);
      drive(tbl[(m_prev + 1) % 12], 1'b1, 1'b0, 1'b0);
      iter++;
    end
    n_cmp++;
    if ({err_cnt, locked} !== {ERR_W'(ERR_SAT), 1'b1}) begin
      n_bad++;
      $display("FAIL err_reach_max: got err=%0d lk=%b required %0d 1", err_cnt, locked, ERR_SAT);
    end
    drive(tbl[(m_prev + 2) % 12], 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({seq_err, err_cnt} !== {1'b1, ERR_W'(ERR_SAT)}) begin
      n_bad++;
      $display("FAIL err_saturate: got se=%b err=%0d required 1 %0d", seq_err, err_cnt, ERR_SAT);
    end
    drive(tbl[(m_prev + 1) % 12], 1'b1, 1'b0, 1'b0);
    drive(tbl[(m_prev + 2) % 12], 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({seq_err, err_cnt} !== {1'b1, ERR_W'(1)}) begin
      n_bad++;
      $display("FAIL err_clr_with_event: got se=%b err=%0d required 1 1", seq_err, err_cnt);
    end
    drive(4'b0000, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({err_cnt, idx_vld, seq_err, illegal, wrap} !== {ERR_W'(0), 4'b0000}) begin
      n_bad++;
      $display("FAIL err_clr_alone: got err=%0d vld=%b se=%b ill=%b wr=%b required 0 0 0 0 0",
               err_cnt, idx_vld, seq_err, illegal, wrap);
    end
  endtask

  task automatic test_reset_mid_lock();
    int iter = 0;
    while (m_prev != 7 && iter < 12) begin
      drive(tbl[(m_prev + 1) % 12], 1'b1, 1'b0, 1'b0);
      iter++;
    end
    n_cmp++;
    if ({idx, locked} !== {4'd7, 1'b1}) begin
      n_bad++;
      $display("FAIL pre_reset_lock: got idx=%0d lk=%b required 7 1", idx, locked);
    end
    drive(tbl[8], 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({idx, idx_vld, locked, illegal, seq_err, wrap, err_cnt} !== '0) begin
      n_bad++;
      $display("FAIL mid_lock_reset: got idx=%0d vld=%b lk=%b ill=%b se=%b wr=%b err=%0d required all 0",
               idx, idx_vld, locked, illegal, seq_err, wrap, err_cnt);
    end
    for (int i = 8; i <= 11; i++) begin
      drive(tbl[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({idx, locked, seq_err} !== {4'(i), i == 11, 1'b0}) begin
        n_bad++;
        $display("FAIL relock[%0d]: got idx=%0d lk=%b se=%b required idx=%0d lk=%b se=0",
                 i, idx, locked, seq_err, i, i == 11);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] c;
    int r;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      c = tbl[(m_prev + 1) % 12];
      else if (r < 85) c = 4'($urandom_range(0, 15));
      else             c = tbl[$urandom_range(0, 11)];
      drive(c, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 399) == 0);
      n_cmp++;
      if ({idx, idx_vld, locked, illegal, seq_err, wrap, err_cnt} !==
          {e_idx, e_idx_vld, m_locked != 0, e_illegal, e_seq_err, e_wrap, ERR_W'(m_err)}) begin
        n_bad++;
        $display("FAIL random[%0d]: got idx=%0d vld=%b lk=%b ill=%b se=%b wr=%b err=%0d required idx=%0d vld=%b lk=%0d ill=%b se=%b wr=%b err=%0d",
                 n, idx, idx_vld, locked, illegal, seq_err, wrap, err_cnt,
                 e_idx, e_idx_vld, m_locked, e_illegal, e_seq_err, e_wrap, m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1; code_in = '0; code_vld = 1'b0; err_clr = 1'b0;
    e_idx = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_lock();
    test_wrap();
    test_illegal_unlock();
    test_resync();
    test_err_saturation();
    test_reset_mid_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq12_code_checker.md
Name: seq12_code_checker

Overview:
- Receive-side partner of the 4-bit mod-12 custom-code counter. Samples the counter's 4-bit state word and decodes it to a binary index 0..11.
- Detects illegal codes and out-of-sequence steps, and maintains a lock state machine with a saturating error counter.
- Sits downstream of the counter and reports sequence health to the test or status logic.

Parameters:
- LOCK_N, 3: consecutive correct transitions required in HUNT to enter LOCKED (legal range 1..15).
- UNLOCK_N, 2: consecutive bad samples in LOCKED that force a return to HUNT (legal range 1..15).
- ERR_W, 8: width of err_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- code_in  in  4  counter state word {Q3,Q2,Q1,Q0}.
- code_vld  in  1  code_in is sampled this cycle.
- err_clr  in  1  clears err_cnt.
- idx  out  4  decoded index of the last legal sample.
- idx_vld  out  1  one-cycle pulse: idx updated.
- locked  out  1  FSM is in LOCKED.
- illegal  out  1  one-cycle pulse: the sampled code is not in the table.
- seq_err  out  1  one-cycle pulse: bad sample while LOCKED.
- wrap  out  1  one-cycle pulse: correct step 11->0 while LOCKED.
- err_cnt  out  ERR_W  saturating count of seq_err events.

Behaviour:
- Code table (index:code): 0:1000, 1:1010, 2:1011, 3:1101, 4:1110, 5:1111, 6:0000, 7:0001, 8:0010, 9:0100, 10:0101, 11:0111.
- Illegal codes: 0011, 0110, 1001, 1100.
- Reset (rst=1 at a clock edge):
  - state=HUNT.
  - idx=0, idx_vld=0, locked=0, illegal=0, seq_err=0, wrap=0, err_cnt=0.
  - Internal registers: prev_idx=0, have_prev=0, run_cnt=0, miss_cnt=0.
  - rst has priority over all inputs, including in mid-lock.
- Latency: every output reflects the sample taken at edge N, registered at edge N+1 (one cycle).
- When code_vld=0: no state change; all pulse outputs are 0 next cycle; idx holds.
- Per sample (code_vld=1):
  - dec = table lookup of code_in; legal = code is in the table.
  - exp = (prev_idx==11) ? 0 : prev_idx+1.
  - good = legal & have_prev & (dec==exp).
  - If legal: idx<=dec, idx_vld<=1, prev_idx<=dec, have_prev<=1.
  - If illegal: illegal<=1, have_prev<=0; idx and prev_idx hold.
- HUNT state:
  - good: run_cnt+1. If the new value equals LOCK_N, go to LOCKED with run_cnt=0 and miss_cnt=0.
  - not good: run_cnt=0.
  - seq_err is never asserted in HUNT.
- LOCKED state:
  - good: miss_cnt=0. If dec==0, wrap<=1.
  - not good (illegal, or legal but out of order): seq_err<=1 and miss_cnt+1. If the new value equals UNLOCK_N, go to HUNT with run_cnt=0.
  - A legal out-of-order sample resynchronises prev_idx to dec.
- locked = (state==LOCKED), registered; it rises one cycle after the locking sample.
- err_cnt:
  - +1 on each seq_err assertion, saturating at 2^ERR_W-1.
  - err_clr alone: err_cnt<=0.
  - err_clr together with a seq_err event: err_cnt<=1, so no event is lost.
- A repeated code (counter stalled while code_vld=1) is treated as out of order.

Decomposition:
- Package seq12_pkg holds:
  - state enum {HUNT, LOCKED};
  - the 12 code constants;
  - ILLEGAL set documentation;
  - the next-index function.
- One combinational sub-module, seq12_decode: code_in -> {legal, dec[3:0]}.
  - The same table is reused by the bench as its reference model.

Test Plan:
- Reset, then feed 1000,1010,1011,1101 with code_vld=1 each cycle -> idx=0,1,2,3 with idx_vld pulses; locked=1 one cycle after the 1101 sample; seq_err=0 throughout.
- After locking, continue through 0101,0111,1000 -> idx=10,11,0; wrap=1 for exactly one cycle, on the 1000 sample's output cycle; err_cnt=0.
- While LOCKED at idx=3, feed 1001 then 1110 -> cycle 1: illegal=1, seq_err=1, idx holds 3. Cycle 2: not good because have_prev=0; seq_err=1, miss_cnt reaches 2, locked=0; err_cnt=2.
- While LOCKED at idx=5 (1111), feed 0010 then 0100 -> first sample: seq_err=1, idx=8, locked stays 1. Second sample is good: miss_cnt=0, no seq_err.
- With err_cnt=255 (ERR_W=8), force another seq_err -> err_cnt stays 255. Then assert err_clr in the same cycle as a seq_err event -> err_cnt=1.
- Assert rst mid-lock at idx=7 with code_vld=1 -> next cycle all outputs are 0 and state is HUNT. The following 0010,0100,0101,0111 samples relock after the third correct step.
